// File: rtl/matrix_pkg.sv
// Shared types and constants for the 4x4 fixed-point matrix multiplier.
package matrix_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_FRAC  = 12;
   localparam int DIM       = 4;
   localparam int NELEM     = DIM * DIM;

   localparam logic [31:0] ONE = 32'h0000_1000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/matrix_mac.sv
// Multiply-accumulate datapath: full-precision product, wide accumulator,
// shift and narrow to WIDTH. MATRIX_MULTIPLY_SAT_EN selects saturation.
module matrix_mac
   import matrix_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int FRAC  = DEF_FRAC
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic             last,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result
);

   localparam int AW = 2 * WIDTH + 2;

   logic signed [2*WIDTH-1:0] ax;
   logic signed [2*WIDTH-1:0] bx;
   logic signed [2*WIDTH-1:0] prod;
   logic signed [AW-1:0]      acc;
   logic signed [AW-1:0]      sum;

   assign ax   = {{WIDTH{a[WIDTH-1]}}, a};
   assign bx   = {{WIDTH{b[WIDTH-1]}}, b};
   assign prod = ax * bx;
   assign sum  = acc + {{2{prod[2*WIDTH-1]}}, prod};

`ifdef MATRIX_MULTIPLY_SAT_EN
   logic signed [AW-1:0]   sh;
   logic [AW-WIDTH:0]      hi;

   assign sh = sum >>> FRAC;
   assign hi = sh[AW-1:WIDTH-1];

   // In range only when every bit above the result sign matches it.
   always_comb begin
      result = sh[WIDTH-1:0];
      if (!(&hi || ~|hi)) begin
         if (sh[AW-1])
            result = {1'b1, {(WIDTH-1){1'b0}}};
         else
            result = {1'b0, {(WIDTH-1){1'b1}}};
      end
   end
`else
   assign result = WIDTH'(sum >>> FRAC);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         acc <= '0;
      else if (clr)
         acc <= '0;
      else if (en)
         acc <= last ? '0 : sum;
   end

endmodule

// File: rtl/matrix_multiply.sv
// 4x4 signed fixed-point matrix multiply, one MAC per cycle (64 cycles).
// Define MATRIX_MULTIPLY_SAT_EN for saturating output narrowing.
module matrix_multiply
   import matrix_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int FRAC  = DEF_FRAC
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [16*WIDTH-1:0]   Ain,
   input  logic [16*WIDTH-1:0]   Bin,
   output logic [16*WIDTH-1:0]   Cout,
   output logic                  busy,
   output logic                  done
);

   state_t state;

   logic [1:0] row;
   logic [1:0] col;
   logic [1:0] k;

   logic [WIDTH-1:0] a_q [NELEM];
   logic [WIDTH-1:0] b_q [NELEM];
   logic [WIDTH-1:0] c_q [NELEM];

   logic [16*WIDTH-1:0] c_flat;
   logic [WIDTH-1:0]    mac_res;
   logic                load;
   logic                store;
   logic                last;

   assign last  = (k == 2'd3);
   assign load  = (state == IDLE) && start;
   assign store = (state == MAC) && last;

   matrix_mac #(
      .WIDTH (WIDTH),
      .FRAC  (FRAC)
   ) u_mac (
      .clk    (clk),
      .rst    (rst),
      .clr    (load),
      .en     (state == MAC),
      .last   (last),
      .a      (a_q[{row, k}]),
      .b      (b_q[{k, col}]),
      .result (mac_res)
   );

   // Operand and result arrays carry no reset; only the FSM does.
   always_ff @(posedge clk) begin
      if (load) begin
         for (int i = 0; i < NELEM; i++) begin
            a_q[i] <= Ain[i*WIDTH +: WIDTH];
            b_q[i] <= Bin[i*WIDTH +: WIDTH];
         end
      end
      if (store)
         c_q[{row, col}] <= mac_res;
   end

   always_comb begin
      c_flat = '0;
      for (int i = 0; i < NELEM; i++)
         c_flat[i*WIDTH +: WIDTH] = c_q[i];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         Cout  <= '0;
         row   <= '0;
         col   <= '0;
         k     <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  row   <= '0;
                  col   <= '0;
                  k     <= '0;
                  busy  <= 1'b1;
                  state <= MAC;
               end
            end
            MAC: begin
               k <= k + 2'd1;
               if (last) begin
                  col <= col + 2'd1;
                  if (col == 2'd3) begin
                     row <= row + 2'd1;
                     if (row == 2'd3) begin
                        busy  <= 1'b0;
                        state <= DONE;
                     end
                  end
               end
            end
            DONE: begin
               if (!done) begin
                  done <= 1'b1;
                  Cout <= c_flat;
               end
               if (!start)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_matrix_multiply.sv
// Directed bench for matrix_multiply with hand-computed Q20.12 results.
module tb_matrix_multiply;

   localparam int W = 32;
   localparam int N = 16 * W;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [N-1:0] ain;
   logic [N-1:0] bin;
   logic [N-1:0] cout;
   logic         busy;
   logic         done;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   matrix_multiply #(
      .WIDTH (W),
      .FRAC  (12)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .Ain   (ain),
      .Bin   (bin),
      .Cout  (cout),
      .busy  (busy),
      .done  (done)
   );

   task automatic check(input string tag,
                        input logic [N-1:0] got,
                        input logic [N-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [N-1:0] diag(input logic [W-1:0] v);
      logic [N-1:0] m;
      m = '0;
      for (int i = 0; i < 4; i++)
         m[(i*5)*W +: W] = v;
      return m;
   endfunction

   function automatic logic [N-1:0] fill(input logic [W-1:0] v);
      logic [N-1:0] m;
      for (int i = 0; i < 16; i++)
         m[i*W +: W] = v;
      return m;
   endfunction

   // Start a multiply, scramble inputs after the latching edge,
   // then count busy cycles and edges until done.
   task automatic run(input logic [N-1:0] a,
                      input logic [N-1:0] b,
                      output int lat,
                      output int bcnt);
      @(negedge clk);
      ain   = a;
      bin   = b;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      ain   = ~a;
      bin   = {b[N-W-1:0], b[N-1:N-W]} ^ fill(32'h5A5A_A5A5);
      bcnt  = busy ? 1 : 0;
      lat   = 0;
      for (int c = 1; c <= 200; c++) begin
         @(posedge clk);
         #1;
         if (busy)
            bcnt++;
         if (done) begin
            lat = c;
            break;
         end
      end
   endtask

   logic [W-1:0] mv [16];
   logic [N-1:0] m_ident;
   logic [N-1:0] exp_ovf;
   int           lat;
   int           bcnt;
   logic         ok;

   initial begin
      mv = '{32'h0000_1000, 32'hFFFF_F000, 32'h7FFF_FFFF, 32'h8000_0000,
             32'h0001_2345, 32'hFFFE_DCBB, 32'h0000_0001, 32'hFFFF_FFFF,
             32'h1234_5678, 32'h8765_4321, 32'h0000_0800, 32'hDEAD_BEEF,
             32'h0F0F_0F0F, 32'hF0F0_F0F0, 32'h0000_0000, 32'h4000_0000};
      for (int i = 0; i < 16; i++)
         m_ident[i*W +: W] = mv[i];

`ifdef MATRIX_MULTIPLY_SAT_EN
      exp_ovf = fill(32'h7FFF_FFFF);
`else
      exp_ovf = fill(32'h0000_4000);
`endif

      rst   = 1'b1;
      start = 1'b0;
      ain   = '0;
      bin   = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_done", N'(done), N'(1'b0));
      check("rst_busy", N'(busy), N'(1'b0));
      check("rst_cout", cout, '0);
      @(negedge clk);
      rst = 1'b0;

      run(diag(32'h0000_1000), m_ident, lat, bcnt);
      check("ident_lat", N'(lat), N'(65));
      check("ident_busy", N'(bcnt), N'(64));
      check("ident_cout", cout, m_ident);
      repeat (3) @(posedge clk);
      #1;
      check("ident_idle", N'(done), N'(1'b0));
      check("ident_hold", cout, m_ident);

      run(diag(32'h0000_2000), diag(32'h0000_0800), lat, bcnt);
      check("half_cout", cout, diag(32'h0000_1000));
      repeat (3) @(posedge clk);

      run(fill(32'hFFFF_E800), fill(32'h0000_2000), lat, bcnt);
      check("neg_cout", cout, fill(32'hFFFF_4000));
      check("neg_lat", N'(lat), N'(65));
      repeat (3) @(posedge clk);

      run(fill(32'h7FFF_F000), fill(32'h7FFF_F000), lat, bcnt);
      check("ovf_cout", cout, exp_ovf);
      repeat (3) @(posedge clk);

      // Reset in the middle of MAC.
      @(negedge clk);
      ain   = fill(32'hFFFF_E800);
      bin   = fill(32'h0000_2000);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (30) @(posedge clk);
      @(negedge clk);
      check("pre_rst_busy", N'(busy), N'(1'b1));
      rst = 1'b1;
      #1;
      check("mid_rst_done", N'(done), N'(1'b0));
      check("mid_rst_busy", N'(busy), N'(1'b0));
      check("mid_rst_cout", cout, '0);
      @(negedge clk);
      rst = 1'b0;
      run(diag(32'h0000_2000), diag(32'h0000_0800), lat, bcnt);
      check("post_rst_cout", cout, diag(32'h0000_1000));
      check("post_rst_lat", N'(lat), N'(65));
      repeat (3) @(posedge clk);

      // Hold start past done.
      @(negedge clk);
      ain   = fill(32'hFFFF_E800);
      bin   = fill(32'h0000_2000);
      start = 1'b1;
      lat   = 0;
      for (int c = 1; c <= 200; c++) begin
         @(posedge clk);
         #1;
         if (done) begin
            lat = c;
            break;
         end
      end
      check("held_lat", N'(lat), N'(66));
      ok = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         if (!done || busy)
            ok = 1'b0;
      end
      check("held_stay", N'(ok), N'(1'b1));
      check("held_cout", cout, fill(32'hFFFF_4000));
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #1;
      check("rel_done_lag", N'(done), N'(1'b1));
      @(posedge clk);
      #1;
      check("rel_done_low", N'(done), N'(1'b0));

      run(diag(32'h0000_1000), m_ident, lat, bcnt);
      check("restart_cout", cout, m_ident);
      check("restart_busy", N'(bcnt), N'(64));

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
